// File: rtl/ir_pkg.sv
// Shared constants for the NEC IR receiver: phase windows (in ticks), FSM
// state encoding and the register map.
package ir_pkg;

    localparam int          WIDTH_BITS = 11;
    localparam logic [10:0] WIDTH_MAX  = 11'd2047;

    // Phase windows in measurement ticks (10 us each at the default tick).
    localparam logic [10:0] LEAD_MARK_MIN  = 11'd800;
    localparam logic [10:0] LEAD_MARK_MAX  = 11'd1000;
    localparam logic [10:0] LEAD_SPACE_MIN = 11'd400;
    localparam logic [10:0] LEAD_SPACE_MAX = 11'd500;
    localparam logic [10:0] REP_SPACE_MIN  = 11'd200;
    localparam logic [10:0] REP_SPACE_MAX  = 11'd260;
    localparam logic [10:0] SHORT_MIN      = 11'd40;
    localparam logic [10:0] SHORT_MAX      = 11'd70;
    localparam logic [10:0] ONE_SPACE_MIN  = 11'd150;
    localparam logic [10:0] ONE_SPACE_MAX  = 11'd190;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5
    } ir_state_e;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    function automatic logic in_win(input logic [10:0] w,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_edge_timer.sv
// Synchronizes the raw IR line, generates the measurement tick and times
// each phase of the line in ticks, reporting the width on every edge.
module ir_edge_timer #(
    parameter int DIV = 500
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ir_i,
    output logic        ir_clean_o,
    output logic        rise_o,
    output logic        fall_o,
    output logic [10:0] width_o,
    output logic        sat_o
);
    import ir_pkg::*;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q;
    logic          sync1_q, sync2_q, prev_q;
    logic [10:0]   width_q;
    logic          tick;

    assign tick       = (div_q == DW'(DIV - 1));
    assign rise_o     = sync2_q & ~prev_q;
    assign fall_o     = ~sync2_q & prev_q;
    assign width_o    = width_q;
    assign sat_o      = (width_q == WIDTH_MAX);
    assign ir_clean_o = sync2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            div_q   <= '0;
            width_q <= '0;
        end else begin
            sync1_q <= ir_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            div_q   <= tick ? '0 : div_q + DW'(1);
            // Width restarts on each edge; saturation doubles as the timeout.
            if (rise_o || fall_o)
                width_q <= '0;
            else if (tick && (width_q != WIDTH_MAX))
                width_q <= width_q + 11'd1;
        end
    end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder with an Avalon-MM register interface
// (status / data / ctrl) and a level interrupt.
module ir_nec_rx #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_US = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_in,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        ir_clean
);
    import ir_pkg::*;

    localparam longint DIV_L = (longint'(CLK_HZ) * longint'(TICK_US)) / 64'd1000000;
    localparam int     DIV   = int'(DIV_L);

    logic        rise, fall, sat;
    logic [10:0] width;

    ir_edge_timer #(.DIV(DIV)) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .ir_i       (ir_in),
        .ir_clean_o (ir_clean),
        .rise_o     (rise),
        .fall_o     (fall),
        .width_o    (width),
        .sat_o      (sat)
    );

    ir_state_e   state_q;
    logic [5:0]  bitcnt_q;
    logic [31:0] shift_q;
    logic        done_q, rep_q, is_rep_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            done_q   <= 1'b0;
            rep_q    <= 1'b0;
            is_rep_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rep_q  <= 1'b0;
            if ((state_q != IDLE) && sat) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (fall) state_q <= LEAD_MARK;
                    LEAD_MARK: if (rise)
                        state_q <= in_win(width, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SPACE : IDLE;
                    LEAD_SPACE: if (fall) begin
                        if (in_win(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            bitcnt_q <= '0;
                            is_rep_q <= 1'b0;
                            state_q  <= BIT_MARK;
                        end else if (in_win(width, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                            rep_q    <= 1'b1;
                            is_rep_q <= 1'b1;
                            state_q  <= STOP_MARK;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    BIT_MARK: if (rise)
                        state_q <= in_win(width, SHORT_MIN, SHORT_MAX) ? BIT_SPACE : IDLE;
                    BIT_SPACE: if (fall) begin
                        if (in_win(width, SHORT_MIN, SHORT_MAX) ||
                            in_win(width, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                            shift_q  <= {in_win(width, ONE_SPACE_MIN, ONE_SPACE_MAX), shift_q[31:1]};
                            bitcnt_q <= bitcnt_q + 6'd1;
                            state_q  <= (bitcnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    STOP_MARK: if (rise) begin
                        // A repeat code carries no payload, so it never reaches the check.
                        done_q  <= in_win(width, SHORT_MIN, SHORT_MAX) && !is_rep_q;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Status bits: {err, repeat, overrun, valid}; a set beats a same-cycle clear.
    logic [3:0]  status_q, status_set, status_clr;
    logic [31:0] data_q, rdata_q;
    logic        irq_en_q, chk_ok, load;

    assign chk_ok     = (shift_q[31:24] == ~shift_q[23:16]);
    assign load       = done_q & chk_ok;
    assign status_set = {done_q & ~chk_ok, rep_q, load & status_q[0], load};
    assign status_clr = (write && (address == REG_STATUS)) ? writedata[3:0] : 4'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
            data_q   <= '0;
            irq_en_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            status_q <= (status_q & ~status_clr) | status_set;
            if (load)
                data_q <= shift_q;
            if (write && (address == REG_CTRL))
                irq_en_q <= writedata[0];
            case (address)
                REG_STATUS: rdata_q <= {28'd0, status_q};
                REG_DATA:   rdata_q <= data_q;
                REG_CTRL:   rdata_q <= {31'd0, irq_en_q};
                default:    rdata_q <= '0;
            endcase
        end
    end

    assign readdata = rdata_q;
    assign irq      = status_q[0] & irq_en_q;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:4];

endmodule

// File: tb/tb_ir_nec_rx.sv
// Bench for ir_nec_rx: drives NEC waveforms in tick units (one tick per clock)
// and checks the register file against expected values.
module tb_ir_nec_rx;

    localparam int CLK_HZ  = 100000;
    localparam int TICK_US = 10;

    logic        clk = 1'b0;
    logic        reset, ir_in, write;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;
    logic        irq, ir_clean;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] w_a, w_b, w_c, w_d;

    always #5 clk = ~clk;

    ir_nec_rx #(.CLK_HZ(CLK_HZ), .TICK_US(TICK_US)) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_in     (ir_in),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .ir_clean  (ir_clean)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    task automatic drive(input logic lvl, input int n);
        @(negedge clk) ir_in = lvl;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_lead();
        drive(1'b0, 900);
        drive(1'b1, 450);
    endtask

    task automatic send_bits(input logic [31:0] word, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(1'b0, 56);
            drive(1'b1, word[i] ? 169 : 56);
        end
    endtask

    task automatic send_frame(input logic [31:0] word);
        send_lead();
        send_bits(word, 0, 31);
        drive(1'b0, 56);
        @(negedge clk) ir_in = 1'b1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk) write = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk) address = a;
        @(negedge clk) d = readdata;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic check_sb(input string tag);
        logic [31:0] d;
        reg_read(2'd1, d);
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) check(tag, d, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; ir_in = 1'b1; write = 1'b0; address = '0; writedata = '0;
        repeat (4) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_clean", {31'd0, ir_clean}, 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        check("clean_idle", {31'd0, ir_clean}, 32'd1);
        expect_reg("rst_status", 2'd0, 32'd0);
        expect_reg("rst_data", 2'd1, 32'd0);
        expect_reg("rst_ctrl", 2'd2, 32'd0);
        reg_write(2'd2, 32'd1);
        expect_reg("ctrl_en", 2'd2, 32'd1);
        expect_reg("addr3", 2'd3, 32'd0);

        // Basic frame addr=0x00 cmd=0x45
        exp_q.push_back(32'hBA45FF00);
        send_frame(nec_word(8'h00, 8'h45));
        drive(1'b1, 100);
        expect_reg("t1_status", 2'd0, 32'd1);
        check_sb("t1_data");
        check("t1_irq", {31'd0, irq}, 32'd1);

        // Repeat code
        reg_write(2'd0, 32'hF);
        check("t2_irq_clr", {31'd0, irq}, 32'd0);
        drive(1'b0, 900); drive(1'b1, 225); drive(1'b0, 56); drive(1'b1, 200);
        expect_reg("t2_status", 2'd0, 32'd4);
        expect_reg("t2_data", 2'd1, 32'hBA45FF00);

        // Overrun
        reg_write(2'd0, 32'hF);
        w_a = nec_word(8'h80, 8'h1C);
        send_frame(32'hBA45FF00);
        drive(1'b1, 100);
        exp_q.push_back(w_a);
        send_frame(w_a);
        drive(1'b1, 100);
        expect_reg("t3_status", 2'd0, 32'd3);
        check_sb("t3_data");

        // Corrupted command inverse
        reg_write(2'd0, 32'hF);
        send_frame(32'hBB45FF00);
        drive(1'b1, 100);
        expect_reg("t4_status", 2'd0, 32'd8);
        expect_reg("t4_data", 2'd1, w_a);

        // 30 ms low mid-frame, then a good frame
        reg_write(2'd0, 32'hF);
        w_b = nec_word(8'h12, 8'h34);
        send_lead();
        send_bits(w_b, 0, 4);
        drive(1'b0, 3000);
        drive(1'b1, 100);
        expect_reg("t5_to_status", 2'd0, 32'd0);
        exp_q.push_back(w_b);
        send_frame(w_b);
        drive(1'b1, 100);
        expect_reg("t5_status", 2'd0, 32'd1);
        check_sb("t5_data");

        // W1C on valid in the cycle the frame lands
        reg_write(2'd0, 32'hF);
        w_c = nec_word(8'hA5, 8'h3C);
        exp_q.push_back(w_c);
        send_frame(w_c);
        repeat (3) @(negedge clk);
        address = 2'd0; writedata = 32'd1; write = 1'b1;
        @(negedge clk) write = 1'b0;
        drive(1'b1, 50);
        expect_reg("t6_status", 2'd0, 32'd1);
        check_sb("t6_data");

        // Reset during bit 10
        send_lead();
        send_bits(w_c, 0, 9);
        @(negedge clk) ir_in = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_rst_readdata", readdata, 32'd0);
        check("t7_rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        ir_in = 1'b1;
        drive(1'b1, 60);
        send_bits(w_c, 11, 31);
        drive(1'b0, 56);
        drive(1'b1, 100);
        expect_reg("t7_status", 2'd0, 32'd0);
        expect_reg("t7_data", 2'd1, 32'd0);
        expect_reg("t7_ctrl", 2'd2, 32'd0);
        check("t7_irq", {31'd0, irq}, 32'd0);

        // Recovery after reset
        reg_write(2'd2, 32'd1);
        w_d = nec_word(8'h5A, 8'hC3);
        exp_q.push_back(w_d);
        send_frame(w_d);
        drive(1'b1, 100);
        expect_reg("t8_status", 2'd0, 32'd1);
        check_sb("t8_data");
        check("t8_irq", {31'd0, irq}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
